// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
//   Shares the single VRAM read port between video scanout fetch and CPU MMIO
//   access, and turns partial CPU stores into a 16-bit byte-lane
//   read-modify-write. Video normally owns the read port; a wait counter lets
//   a starved CPU read take the port once it has been denied STARVE times.
//
// Ports
//   i_clk, i_reset      single clock, synchronous active-high reset
//   i_vid_req/addr      video read request (held until o_vid_ack)
//   o_vid_ack/rdata     one-cycle ack; data is the RAM output that cycle
//   i_cpu_valid/addr/   CPU access; wstrb all-zero = read, all-ones = full
//     wstrb/wdata       write, anything else = partial write (RMW)
//   o_cpu_ready/rdata   one-cycle completion; rdata held between reads
//   o_mem_ren/raddr     RAM read port, combinational from the grant
//   i_mem_rdata         RAM read data, one cycle after o_mem_ren
//   o_mem_wen/waddr/    RAM write port, registered
//     wdata
// ---------------------------------------------------------------------------
module vram_port_arbiter #(
  parameter int AW     = 15,
  parameter int DW     = 16,
  parameter int STARVE = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vid_req,
  input  logic [AW-1:0]     i_vid_addr,
  output logic              o_vid_ack,
  output logic [DW-1:0]     o_vid_rdata,
  input  logic              i_cpu_valid,
  input  logic [AW-1:0]     i_cpu_addr,
  input  logic [DW/8-1:0]   i_cpu_wstrb,
  input  logic [DW-1:0]     i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic [DW-1:0]     o_cpu_rdata,
  output logic              o_mem_ren,
  output logic [AW-1:0]     o_mem_raddr,
  input  logic [DW-1:0]     i_mem_rdata,
  output logic              o_mem_wen,
  output logic [AW-1:0]     o_mem_waddr,
  output logic [DW-1:0]     o_mem_wdata
);

  localparam int LANES = DW / 8;
  localparam logic [LANES-1:0] STRB_NONE = {LANES{1'b0}};
  localparam logic [LANES-1:0] STRB_ALL  = {LANES{1'b1}};
  localparam logic [7:0]       STARVE_C  = 8'(STARVE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_wait_cnt;
  logic                 r_vid_ack;
  logic                 r_cpu_ready;
  logic [DW-1:0]        r_cpu_rdata;
  logic                 r_mem_wen;
  logic [AW-1:0]        r_mem_waddr;
  logic [DW-1:0]        r_mem_wdata;
  logic [AW-1:0]        r_addr;
  logic [LANES-1:0]     r_wstrb;
  logic [DW-1:0]        r_wdata;

  logic                 w_idle;
  logic                 w_cpu_rd_need;
  logic                 w_cpu_full_wr;
  logic                 w_starved;
  logic                 w_cpu_grant;
  logic                 w_vid_grant;

  // Byte-lane merge: strobed lanes come from the CPU, the rest from RAM.
  function automatic logic [DW-1:0] merge_lanes(
    input logic [DW-1:0]    old_word,
    input logic [DW-1:0]    new_word,
    input logic [LANES-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Read-port grant; gated by reset so nothing reaches the RAM during reset.
  always_comb begin
    w_idle        = (r_state == ST_IDLE);
    w_cpu_rd_need = !i_reset && w_idle && i_cpu_valid && (i_cpu_wstrb != STRB_ALL);
    w_cpu_full_wr = !i_reset && w_idle && i_cpu_valid && (i_cpu_wstrb == STRB_ALL);
    w_starved     = (r_wait_cnt == STARVE_C);
    w_cpu_grant   = w_cpu_rd_need && (!i_vid_req || w_starved);
    w_vid_grant   = !i_reset && !w_cpu_grant && i_vid_req;
    o_mem_ren     = 1'b0;
    o_mem_raddr   = i_vid_addr;
    if (w_cpu_grant) begin
      o_mem_ren   = 1'b1;
      o_mem_raddr = i_cpu_addr;
    end else if (w_vid_grant) begin
      o_mem_ren   = 1'b1;
      o_mem_raddr = i_vid_addr;
    end else begin
      o_mem_ren   = 1'b0;
      o_mem_raddr = i_vid_addr;
    end
  end

  // CPU access FSM, starvation counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 8'd0;
      r_vid_ack   <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= {DW{1'b0}};
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_addr      <= {AW{1'b0}};
      r_wstrb     <= STRB_NONE;
      r_wdata     <= {DW{1'b0}};
    end else begin
      r_vid_ack   <= w_vid_grant;
      r_cpu_ready <= 1'b0;
      r_mem_wen   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_full_wr) begin
            // Full-word store needs no read, so video is never in the way.
            r_mem_wen   <= 1'b1;
            r_mem_waddr <= i_cpu_addr;
            r_mem_wdata <= i_cpu_wdata;
            r_cpu_ready <= 1'b1;
            r_wait_cnt  <= 8'd0;
            r_state     <= ST_DONE;
          end else if (w_cpu_grant) begin
            r_addr     <= i_cpu_addr;
            r_wstrb    <= i_cpu_wstrb;
            r_wdata    <= i_cpu_wdata;
            r_wait_cnt <= 8'd0;
            r_state    <= ST_RDWAIT;
          end else if (w_cpu_rd_need) begin
            r_wait_cnt <= (r_wait_cnt < STARVE_C) ? (r_wait_cnt + 8'd1) : STARVE_C;
          end else begin
            r_wait_cnt <= r_wait_cnt;
          end
        end
        ST_RDWAIT: begin
          // RAM data for the granted read is on i_mem_rdata this cycle.
          r_wait_cnt  <= 8'd0;
          r_cpu_ready <= 1'b1;
          r_state     <= ST_DONE;
          if (r_wstrb == STRB_NONE) begin
            r_cpu_rdata <= i_mem_rdata;
          end else begin
            r_mem_wen   <= 1'b1;
            r_mem_waddr <= r_addr;
            r_mem_wdata <= merge_lanes(i_mem_rdata, r_wdata, r_wstrb);
          end
        end
        ST_DONE: begin
          // The bus drops cpu_valid after ready; ignore it for this cycle.
          r_wait_cnt <= 8'd0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_wait_cnt <= 8'd0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_vid_ack   = r_vid_ack;
  assign o_vid_rdata = i_mem_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_mem_wen   = r_mem_wen;
  assign o_mem_waddr = r_mem_waddr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter: RAM model, transaction-level reference
// model with a per-cycle compare process, directed scenarios with literal
// expectations, then randomized traffic.
module tb_vram_port_arbiter;

  localparam int STARVE = 8;
  localparam int R      = 8;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_vid_req;
  logic [14:0] i_vid_addr;
  logic        o_vid_ack;
  logic [15:0] o_vid_rdata;
  logic        i_cpu_valid;
  logic [14:0] i_cpu_addr;
  logic [1:0]  i_cpu_wstrb;
  logic [15:0] i_cpu_wdata;
  logic        o_cpu_ready;
  logic [15:0] o_cpu_rdata;
  logic        o_mem_ren;
  logic [14:0] o_mem_raddr;
  logic [15:0] ram_q;
  logic        o_mem_wen;
  logic [14:0] o_mem_waddr;
  logic [15:0] o_mem_wdata;

  int errors = 0;
  int checks = 0;

  vram_port_arbiter #(.AW(15), .DW(16), .STARVE(STARVE)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
    .o_vid_ack(o_vid_ack), .o_vid_rdata(o_vid_rdata),
    .i_cpu_valid(i_cpu_valid), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wstrb(i_cpu_wstrb), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ready(o_cpu_ready), .o_cpu_rdata(o_cpu_rdata),
    .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(ram_q),
    .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata)
  );

  always #5 clk = ~clk;

  // Read-first single-port-pair RAM seen by the DUT.
  logic [15:0] ram [32768];
  always @(posedge clk) begin
    if (o_mem_ren === 1'b1) ram_q <= ram[o_mem_raddr];
    if (o_mem_wen === 1'b1) ram[o_mem_waddr] <= o_mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mmem [32768];
  bit          e_vack [R];
  logic [15:0] e_vdata[R];
  bit          e_rdy  [R];
  bit          e_wen  [R];
  logic [14:0] e_waddr[R];
  logic [15:0] e_wdata[R];
  bit          e_rd   [R];
  logic [15:0] e_rval [R];
  int          cyc = 0;
  int          cpu_free = 0;
  int          scnt = 0;
  bit          armed = 0;
  logic [15:0] held = 16'h0000;
  int          s, s1, s2;
  bit          m_idle, m_need, m_cwin, m_vwin;
  logic [15:0] m_old;

  // Compare process: checks this cycle's outputs, then schedules future ones.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      s  = cyc % R;
      s1 = (cyc + 1) % R;
      s2 = (cyc + 2) % R;
      if (armed) begin
        chk("vid_ack", 32'(o_vid_ack), 32'(e_vack[s]));
        if (e_vack[s]) chk("vid_rdata", 32'(o_vid_rdata), 32'(e_vdata[s]));
        chk("cpu_ready", 32'(o_cpu_ready), 32'(e_rdy[s]));
        chk("mem_wen", 32'(o_mem_wen), 32'(e_wen[s]));
        if (e_wen[s]) begin
          chk("mem_waddr", 32'(o_mem_waddr), 32'(e_waddr[s]));
          chk("mem_wdata", 32'(o_mem_wdata), 32'(e_wdata[s]));
        end
        if (e_rd[s]) held = e_rval[s];
        chk("cpu_rdata", 32'(o_cpu_rdata), 32'(held));
      end
      m_idle = (cyc >= cpu_free);
      m_need = !i_reset && m_idle && i_cpu_valid && (i_cpu_wstrb != 2'b11);
      m_cwin = m_need && (!i_vid_req || scnt == STARVE);
      m_vwin = !i_reset && !m_cwin && i_vid_req;
      if (armed) begin
        chk("mem_ren", 32'(o_mem_ren), 32'(m_cwin || m_vwin));
        if (m_cwin || m_vwin)
          chk("mem_raddr", 32'(o_mem_raddr), 32'(m_cwin ? i_cpu_addr : i_vid_addr));
      end
      m_old = m_cwin ? mmem[i_cpu_addr] : mmem[i_vid_addr];
      if (e_wen[s]) mmem[e_waddr[s]] = e_wdata[s];
      e_vack[s] = 0; e_rdy[s] = 0; e_wen[s] = 0; e_rd[s] = 0;
      if (i_reset) begin
        e_vack[s1] = 0; e_rdy[s1] = 0; e_wen[s1] = 0;
        e_vack[s2] = 0; e_rdy[s2] = 0; e_wen[s2] = 0; e_rd[s2] = 0;
        e_rd[s1] = 1; e_rval[s1] = 16'h0000;
        cpu_free = cyc + 1;
        scnt = 0;
        armed = 1;
      end else begin
        if (m_vwin) begin
          e_vack[s1] = 1; e_vdata[s1] = m_old;
        end
        if (m_idle && i_cpu_valid && i_cpu_wstrb == 2'b11) begin
          e_wen[s1] = 1; e_waddr[s1] = i_cpu_addr; e_wdata[s1] = i_cpu_wdata;
          e_rdy[s1] = 1;
          cpu_free = cyc + 2;
        end else if (m_cwin) begin
          e_rdy[s2] = 1;
          if (i_cpu_wstrb == 2'b00) begin
            e_rd[s2] = 1; e_rval[s2] = m_old;
          end else begin
            e_wen[s2] = 1; e_waddr[s2] = i_cpu_addr;
            e_wdata[s2] = {i_cpu_wstrb[1] ? i_cpu_wdata[15:8] : m_old[15:8],
                           i_cpu_wstrb[0] ? i_cpu_wdata[7:0]  : m_old[7:0]};
          end
          cpu_free = cyc + 3;
        end
        if (!m_idle || m_cwin) scnt = 0;
        else if (m_need) scnt = (scnt < STARVE) ? scnt + 1 : STARVE;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    ram[a] = d;
    mmem[a] = d;
  endtask

  // One CPU access from the start of a cycle; returns timing relative to it.
  task automatic cpu_op(input logic [14:0] a, input logic [1:0] st, input logic [15:0] d,
                        output int lat, output int wen_at, output logic [15:0] wd,
                        output logic [14:0] wa, output logic [15:0] rd, output int acks);
    lat = -1; wen_at = -1; wd = 16'h0; wa = 15'h0; rd = 16'h0; acks = 0;
    i_cpu_addr = a; i_cpu_wstrb = st; i_cpu_wdata = d; i_cpu_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_vid_ack) acks++;
      if (o_mem_wen) begin wen_at = c; wd = o_mem_wdata; wa = o_mem_waddr; end
      if (o_cpu_ready) begin lat = c; rd = o_cpu_rdata; break; end
    end
    i_cpu_valid = 1'b0;
    if (lat < 0) chk("cpu_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat, wen_at, acks, k, gaps, nwen, nrdy;
  logic [15:0] wd, rd;
  logic [14:0] wa;
  logic [15:0] vexp [3];

  initial begin
    i_reset = 1'b1; i_vid_req = 1'b0; i_vid_addr = 15'h0;
    i_cpu_valid = 1'b0; i_cpu_addr = 15'h0; i_cpu_wstrb = 2'b00; i_cpu_wdata = 16'h0;
    for (int i = 0; i < 32768; i++) preload(15'(i), 16'h0000);
    for (int i = 0; i < 64; i++) preload(15'(i), 16'($urandom));
    preload(15'h0, 16'hA0A0); preload(15'h1, 16'hB1B1); preload(15'h2, 16'hC2C2);
    preload(15'h10, 16'hBEEF); preload(15'h20, 16'hBEEF);
    vexp[0] = 16'hA0A0; vexp[1] = 16'hB1B1; vexp[2] = 16'hC2C2;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    tick();

    // Video stream: three back-to-back reads with no gaps.
    i_vid_req = 1'b1; i_vid_addr = 15'h0; k = 0; gaps = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      tick();
      if (o_vid_ack) begin
        chk("vstream_data", 32'(o_vid_rdata), 32'(vexp[k]));
        k++;
        if (k < 3) i_vid_addr = 15'(k);
        else i_vid_req = 1'b0;
      end else if (k > 0) gaps++;
    end
    chk("vstream_count", 32'(k), 32'd3);
    chk("vstream_gaps", 32'(gaps), 32'd0);
    tick();

    // CPU read with video idle.
    cpu_op(15'h10, 2'b00, 16'h0, lat, wen_at, wd, wa, rd, acks);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", 32'(rd), 32'hBEEF);
    chk("rd_no_wen", 32'(wen_at), 32'hFFFFFFFF);

    // Partial write: upper lane from CPU, lower lane from RAM.
    cpu_op(15'h20, 2'b10, 16'h12AA, lat, wen_at, wd, wa, rd, acks);
    chk("pw_wen_at", 32'(wen_at), 32'd2);
    chk("pw_wdata", 32'(wd), 32'h12EF);
    chk("pw_waddr", 32'(wa), 32'h20);
    chk("pw_latency", 32'(lat), 32'd2);

    // Starvation: video hogs the port, CPU wins on the 9th cycle.
    i_vid_req = 1'b1; i_vid_addr = 15'h5;
    tick(); tick();
    cpu_op(15'h10, 2'b00, 16'h0, lat, wen_at, wd, wa, rd, acks);
    chk("starve_latency", 32'(lat), 32'(STARVE + 2));
    chk("starve_acks", 32'(acks), 32'(STARVE + 1));
    chk("starve_data", 32'(rd), 32'hBEEF);

    // Full write under contention: one cycle, no video gap.
    cpu_op(15'h21, 2'b11, 16'h5A5A, lat, wen_at, wd, wa, rd, acks);
    chk("fw_latency", 32'(lat), 32'd1);
    chk("fw_wen_at", 32'(wen_at), 32'd1);
    chk("fw_wdata", 32'(wd), 32'h5A5A);
    chk("fw_waddr", 32'(wa), 32'h21);
    chk("fw_acks", 32'(acks), 32'd1);
    i_vid_req = 1'b0;
    tick(); tick();

    // Reset for two cycles in the middle of a CPU read.
    i_cpu_addr = 15'h10; i_cpu_wstrb = 2'b00; i_cpu_valid = 1'b1;
    tick();
    i_reset = 1'b1;
    tick();
    chk("rst_ready", 32'(o_cpu_ready), 32'd0);
    chk("rst_wen", 32'(o_mem_wen), 32'd0);
    chk("rst_vack", 32'(o_vid_ack), 32'd0);
    chk("rst_rdata", 32'(o_cpu_rdata), 32'd0);
    chk("rst_waddr", 32'(o_mem_waddr), 32'd0);
    chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
    chk("rst_ren", 32'(o_mem_ren), 32'd0);
    tick();
    i_reset = 1'b0; i_cpu_valid = 1'b0;
    nwen = 0; nrdy = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_mem_wen) nwen++;
      if (o_cpu_ready) nrdy++;
    end
    chk("rst_no_wen", 32'(nwen), 32'd0);
    chk("rst_no_ready", 32'(nrdy), 32'd0);
    cpu_op(15'h10, 2'b00, 16'h0, lat, wen_at, wd, wa, rd, acks);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_data", 32'(rd), 32'hBEEF);

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_reset) i_reset = 1'b0;
      else if ($urandom_range(299) == 0) begin
        i_reset = 1'b1;
        i_cpu_valid = 1'b0;
      end
      if (!i_vid_req || o_vid_ack) begin
        i_vid_req  = ($urandom_range(3) != 0);
        i_vid_addr = 15'($urandom_range(63));
      end
      if (i_cpu_valid && o_cpu_ready) i_cpu_valid = 1'b0;
      if (!i_cpu_valid && !i_reset && $urandom_range(2) == 0) begin
        i_cpu_addr  = 15'($urandom_range(63));
        i_cpu_wstrb = 2'($urandom_range(3));
        i_cpu_wdata = 16'($urandom);
        i_cpu_valid = 1'b1;
      end
    end
    i_reset = 1'b0; i_vid_req = 1'b0; i_cpu_valid = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
